// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the asynchronous FIFO: binary/Gray write pointers,
// read-pointer synchronizer, and full / almost_full / level / overflow flags.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rd_gray_ptr_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH:0]   wr_bin_ptr_o,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wr_level_o,
  output logic                  overflow_o
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic [PW-1:0] rq_bin;

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  // Plain flop chain: no logic may sit between stages of the CDC synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_gray_ptr_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq = sync_q[SYNC_STAGES-1];

  always_comb begin
    rq_bin = '0;
    for (int i = 0; i < PW; i++) rq_bin[i] = ^(rq >> i);
  end

  assign accept = wr_en_i & ~full_q & ~rst;

  always_comb begin
    bin_d   = bin_q + {{ADDR_WIDTH{1'b0}}, accept};
    gray_d  = bin_d ^ (bin_d >> 1);
    full_d  = (gray_d == {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]});
    level_d = bin_d - rq_bin;
    afull_d = (level_d >= PW'(AFULL_THRESH));
    ovf_d   = wr_en_i & full_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_we_o      = accept;
  assign wr_addr_o     = bin_q[ADDR_WIDTH-1:0];
  assign wr_bin_ptr_o  = bin_q;
  assign wr_gray_ptr_o = gray_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;
  assign wr_level_o    = level_q;
  assign overflow_o    = ovf_q;

endmodule
